// File: rtl/elbeth_fetch_unit.sv
// elbeth_fetch_unit: instruction-fetch stage and IF/ID pipeline register for the ELBETH RV32I core.
//
// Generates the fetch PC and drives a valid/ready instruction-memory port. A one-entry skid buffer
// absorbs decode stalls, and branch/jump/trap redirects are handled through if_flush. The IF/ID
// register goes to the decoder pre-split into opcode and field slices.
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   id_stall              decode cannot accept; hold IF/ID
//   if_flush              redirect request
//   if_flush_target       redirect PC; bits [1:0] are ignored
//   imem_addr/valid       fetch request
//   imem_ready            request accepted; rdata/error are valid in the same cycle
//   imem_rdata/error      instruction word and access fault for the accepted beat
//   id_pc/valid           IF/ID PC and live flag
//   id_opcode, id_inst_*  instruction slices [6:0] [11:7] [14:12] [19:15] [24:20] [31:25]
//   id_fetch_error        IF/ID entry is an instruction-access fault
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        if_flush,
  input  logic [31:0] if_flush_target,
  output logic [31:0] imem_addr,
  output logic        imem_valid,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_inst_0,
  output logic [2:0]  id_inst_1,
  output logic [4:0]  id_inst_2,
  output logic [4:0]  id_inst_3,
  output logic [6:0]  id_inst_4,
  output logic        id_fetch_error
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  // Skid entry; it is occupied exactly while in StHold.
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_err_q, skid_err_d;
  // IF/ID register. id_inst_q already holds NOP_INST for bubbles and faults.
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_err_q, id_err_d;

  logic        accept;
  logic [31:0] target;

  assign imem_valid = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign accept     = imem_valid && imem_ready;
  assign target     = if_flush_target & ~32'h3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    redirect_pc_d = redirect_pc_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    skid_err_d    = skid_err_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    id_err_d      = id_err_q;

    if (if_flush) begin
      // Redirect beats a stall: IF/ID becomes a bubble and any skid entry is lost.
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      id_err_d   = 1'b0;
      if (imem_valid && !imem_ready) begin
        // Address must stay stable until acceptance; drop that beat later instead.
        kill_d        = 1'b1;
        redirect_pc_d = target;
      end else begin
        pc_d    = target;
        kill_d  = 1'b0;
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d = StFetch;
          if (!id_stall) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_err_d   = 1'b0;
          end
        end
        StFetch: begin
          if (accept && kill_q) begin
            pc_d   = redirect_pc_q;
            kill_d = 1'b0;
            if (!id_stall) begin
              id_valid_d = 1'b0;
              id_inst_d  = NOP_INST;
              id_err_d   = 1'b0;
            end
          end else if (accept) begin
            pc_d = pc_q + 32'd4;
            if (id_stall) begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              skid_err_d  = imem_error;
              state_d     = StHold;
            end else begin
              id_pc_d    = pc_q;
              id_inst_d  = imem_error ? NOP_INST : imem_rdata;
              id_err_d   = imem_error;
              id_valid_d = 1'b1;
            end
          end else if (!id_stall) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            id_err_d   = 1'b0;
          end
        end
        StHold: begin
          if (!id_stall) begin
            id_pc_d    = skid_pc_q;
            id_inst_d  = skid_err_q ? NOP_INST : skid_inst_q;
            id_err_d   = skid_err_q;
            id_valid_d = 1'b1;
            state_d    = StFetch;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      redirect_pc_q <= RESET_PC;
      skid_pc_q     <= RESET_PC;
      skid_inst_q   <= NOP_INST;
      skid_err_q    <= 1'b0;
      id_pc_q       <= RESET_PC;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
      id_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      redirect_pc_q <= redirect_pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      skid_err_q    <= skid_err_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      id_err_q      <= id_err_d;
    end
  end

  assign id_pc          = id_pc_q;
  assign id_valid       = id_valid_q;
  assign id_fetch_error = id_err_q;
  assign id_opcode      = id_inst_q[6:0];
  assign id_inst_0      = id_inst_q[11:7];
  assign id_inst_1      = id_inst_q[14:12];
  assign id_inst_2      = id_inst_q[19:15];
  assign id_inst_3      = id_inst_q[24:20];
  assign id_inst_4      = id_inst_q[31:25];

endmodule

// File: doc/elbeth_fetch_unit.md
Name: elbeth_fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the ELBETH RV32I core.
- Generates the PC and drives a valid/ready instruction-memory port.
- Absorbs decode stalls with a one-entry skid buffer.
- Handles branch/jump/trap redirects.
- Presents the registered instruction to the decoder, pre-split into opcode and field slices (opcode, inst_0..inst_4), plus PC, valid and fetch-fault flags.

Parameters:
- RESET_PC, 32'h0000_0200: first fetch address after reset.
- NOP_INST, 32'h0000_0013: instruction shown on the ID fields during bubbles and faults (addi x0,x0,0).

Ports:
- clk, input, 1: core clock.
- rst, input, 1: synchronous, active-high reset.
- id_stall, input, 1: decode cannot accept; hold the IF/ID register.
- if_flush, input, 1: redirect request (taken branch, jal/jalr, trap, eret).
- if_flush_target, input, 32: redirect PC; bits [1:0] are forced to 0 internally.
- imem_addr, output, 32: fetch address.
- imem_valid, output, 1: fetch request.
- imem_ready, input, 1: request accepted; imem_rdata and imem_error are valid in this same cycle.
- imem_rdata, input, 32: instruction word.
- imem_error, input, 1: access fault for this beat.
- id_pc, output, 32: PC of the instruction in IF/ID.
- id_valid, output, 1: IF/ID holds a live instruction.
- id_opcode, output, 7: inst[6:0].
- id_inst_0, output, 5: inst[11:7].
- id_inst_1, output, 3: inst[14:12].
- id_inst_2, output, 5: inst[19:15].
- id_inst_3, output, 5: inst[24:20].
- id_inst_4, output, 7: inst[31:25].
- id_fetch_error, output, 1: the IF/ID entry is an instruction-access fault.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=BOOT, pc=RESET_PC, imem_addr=RESET_PC, imem_valid=0.
  - id_valid=0, id_fetch_error=0, id_pc=RESET_PC, ID fields=NOP_INST slices.
  - kill=0, skid buffer empty.
- States:
  - BOOT: imem_valid=0 for exactly one cycle, then FETCH.
  - FETCH: imem_valid=1, imem_addr=pc.
  - HOLD: skid buffer full, imem_valid=0.
- Handshake:
  - A beat is accepted when imem_valid && imem_ready.
  - Once imem_valid=1, it and imem_addr stay stable until acceptance, whatever happens on id_stall or if_flush.
- Normal beat (FETCH, beat accepted, id_stall=0, kill=0, if_flush=0):
  - At the next edge, IF/ID loads {pc, rdata, imem_error} and id_valid=1; pc += 4.
  - With imem_ready held at 1, throughput is one instruction per cycle and latency is one cycle from acceptance to ID outputs.
- No beat and id_stall=0: IF/ID loads a bubble (id_valid=0, NOP fields, id_fetch_error=0). The decoder never sees a stale instruction twice.
- id_stall=1: IF/ID holds all outputs unchanged.
  - If a beat is accepted in the same cycle, the beat goes into the skid buffer, pc += 4, and state goes to HOLD.
- HOLD:
  - On the first cycle with id_stall=0, skid moves to IF/ID (id_valid=1) and state goes to FETCH; the next request is issued the following cycle.
- Fault (imem_error=1 on an accepted beat):
  - Entry has id_fetch_error=1, id_valid=1, ID fields=NOP_INST, id_pc=faulting address.
  - pc advances normally; the trap redirect arrives via if_flush.
- if_flush (highest priority, overrides id_stall):
  - Next edge: IF/ID is a bubble and the skid buffer is discarded.
  - No request outstanding (BOOT/HOLD, or FETCH with the beat accepted this cycle): pc=target, state=FETCH, and any beat accepted this cycle is discarded.
  - Request outstanding (imem_valid=1, imem_ready=0): address is held; kill=1, redirect_pc=target. When that beat is accepted it is dropped, pc=redirect_pc, kill=0.
  - A further flush while kill=1 overwrites redirect_pc (latest wins).
- Reset mid-request: the request is abandoned and imem_valid=0 the next cycle. The memory is required to tolerate a dropped request across reset.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
- Reset, then imem_ready=1, rdata=32'h00500093 -> imem_addr 0x200 in cycle 2; next cycle id_pc=0x200, id_opcode=7'h13, id_inst_0=1, id_inst_3=5, id_valid=1; then addresses 0x204, 0x208 back-to-back.
- id_stall=1 for 3 cycles while beat at 0x204 is accepted -> IF/ID still shows 0x200, imem_valid=0 during HOLD; after release id_pc=0x204, then request 0x208 issued.
- if_flush, target=0x1003, with imem_ready=0 on 0x208 -> imem_addr stays 0x208; after ready, beat dropped (id_valid stays 0); next imem_addr=0x1000.
- Flush together with id_stall=1 in HOLD -> next cycle id_valid=0, skid dropped, imem_addr=target.
- imem_error=1 on 0x300 -> id_fetch_error=1, id_valid=1, id_opcode=7'h13, other fields 0, id_pc=0x300.
- rst asserted with imem_valid=1, imem_ready=0 -> next cycle imem_valid=0 and id_valid=0; BOOT one cycle; fetch restarts at 0x200.
